// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT defaults, peak finder state type and complex word helpers
package fft_pkg;

    localparam int FFT_BIT_WIDTH = 16;
    localparam int FFT_N         = 9;
    localparam int FFT_MAX_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        REPORT
    } peak_state_e;

    // Real part of a {re, im} word whose components are w bits wide (result zero-padded)
    function automatic logic [FFT_MAX_W-1:0] cplx_re(input logic [2*FFT_MAX_W-1:0] word,
                                                     input int w);
        return FFT_MAX_W'(word >> w);
    endfunction

    // Imaginary part of a {re, im} word; caller keeps the low w bits
    function automatic logic [FFT_MAX_W-1:0] cplx_im(input logic [2*FFT_MAX_W-1:0] word);
        return FFT_MAX_W'(word);
    endfunction

endpackage

// File: rtl/cmag_approx.sv
// rtl/cmag_approx.sv - combinational max + min/2 magnitude estimate of a {re, im} word
module cmag_approx
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = FFT_BIT_WIDTH
) (
    input  logic [2*BIT_WIDTH-1:0] din,
    output logic [BIT_WIDTH-1:0]   mag
);

    localparam logic [BIT_WIDTH-1:0] MAX_POS = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] MIN_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [BIT_WIDTH-1:0] ONE     = {{(BIT_WIDTH-1){1'b0}}, 1'b1};

    logic [FFT_MAX_W-1:0] re_full;
    logic [FFT_MAX_W-1:0] im_full;
    logic [BIT_WIDTH-1:0] re;
    logic [BIT_WIDTH-1:0] im;
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic [BIT_WIDTH-1:0] hi;
    logic [BIT_WIDTH-1:0] lo;
    logic                 unused_hi_bits;

    // Saturating abs of each component (most negative maps to most positive), then max + min/2
    always_comb begin
        re_full = cplx_re((2*FFT_MAX_W)'(din), BIT_WIDTH);
        im_full = cplx_im((2*FFT_MAX_W)'(din));
        re      = re_full[BIT_WIDTH-1:0];
        im      = im_full[BIT_WIDTH-1:0];
        unused_hi_bits = ^{re_full[FFT_MAX_W-1:BIT_WIDTH], im_full[FFT_MAX_W-1:BIT_WIDTH]};

        if (!re[BIT_WIDTH-1]) begin
            a = re;
        end else if (re == MIN_NEG) begin
            a = MAX_POS;
        end else begin
            a = ~re + ONE;
        end

        if (!im[BIT_WIDTH-1]) begin
            b = im;
        end else if (im == MIN_NEG) begin
            b = MAX_POS;
        end else begin
            b = ~im + ONE;
        end

        if (a >= b) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end

        // Both terms are below 2^(W-1), so the sum always fits in W bits
        mag = hi + (lo >> 1);
    end

endmodule

// File: rtl/fft_peak_finder.sv
// rtl/fft_peak_finder.sv - sweeps FFT result RAM half-spectrum, streams magnitudes, reports peak bin
module fft_peak_finder
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = FFT_BIT_WIDTH,
    parameter int N         = FFT_N,
    parameter int START_BIN = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    input  logic [2*BIT_WIDTH-1:0] dout,
    output logic [N-1:0]           rd_add,
    output logic                   busy,
    output logic                   mag_valid,
    output logic [N-1:0]           mag_bin,
    output logic [BIT_WIDTH-1:0]   mag,
    output logic                   peak_valid,
    output logic [N-1:0]           peak_bin,
    output logic [BIT_WIDTH-1:0]   peak_mag
);

    localparam int             M         = 2 ** (N - 1);
    localparam logic [N-1:0]   FIRST_BIN = N'(START_BIN);
    localparam logic [N-1:0]   LAST_BIN  = N'(M - 1);
    localparam logic [N-1:0]   ONE_ADDR  = N'(1);

    peak_state_e            state_q, state_d;
    logic                   done_prev_q, done_prev_d;
    logic [N-1:0]           rd_add_q, rd_add_d;
    logic                   busy_q, busy_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [N-1:0]           s1_bin_q, s1_bin_d;
    logic                   mag_valid_q, mag_valid_d;
    logic [N-1:0]           mag_bin_q, mag_bin_d;
    logic [BIT_WIDTH-1:0]   mag_q, mag_d;
    logic [BIT_WIDTH-1:0]   work_mag_q, work_mag_d;
    logic [N-1:0]           work_bin_q, work_bin_d;
    logic                   peak_valid_q, peak_valid_d;
    logic [N-1:0]           peak_bin_q, peak_bin_d;
    logic [BIT_WIDTH-1:0]   peak_mag_q, peak_mag_d;
    logic [BIT_WIDTH-1:0]   mag_comb;
    logic                   start;

    cmag_approx #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_cmag (
        .din(dout),
        .mag(mag_comb)
    );

    // Next-state logic: sweep FSM, address counter, magnitude pipeline and peak tracking
    always_comb begin
        start        = (state_q == IDLE) && fft_done && !done_prev_q;
        state_d      = state_q;
        done_prev_d  = fft_done;
        rd_add_d     = rd_add_q;
        peak_valid_d = 1'b0;
        peak_bin_d   = peak_bin_q;
        peak_mag_d   = peak_mag_q;
        work_mag_d   = work_mag_q;
        work_bin_d   = work_bin_q;

        // Stage 1 remembers which address the RAM is answering this cycle
        s1_valid_d  = (state_q == SWEEP);
        s1_bin_d    = rd_add_q;

        // Stage 2 registers the magnitude of the word now on dout
        mag_valid_d = s1_valid_q;
        mag_bin_d   = s1_valid_q ? s1_bin_q : '0;
        mag_d       = s1_valid_q ? mag_comb : '0;

        // Strict compare keeps the lowest bin on ties
        if (s1_valid_q && (mag_comb > work_mag_q)) begin
            work_mag_d = mag_comb;
            work_bin_d = s1_bin_q;
        end

        case (state_q)
            IDLE: begin
                rd_add_d = '0;
                if (start) begin
                    state_d    = SWEEP;
                    rd_add_d   = FIRST_BIN;
                    work_mag_d = '0;
                    work_bin_d = FIRST_BIN;
                end
            end
            SWEEP: begin
                if (rd_add_q == LAST_BIN) begin
                    state_d  = DRAIN;
                    rd_add_d = '0;
                end else begin
                    rd_add_d = rd_add_q + ONE_ADDR;
                end
            end
            DRAIN: begin
                // Last magnitude is on the output and already folded into the working max
                if (mag_valid_q && !s1_valid_q) begin
                    state_d      = REPORT;
                    peak_valid_d = 1'b1;
                    peak_bin_d   = work_bin_q;
                    peak_mag_d   = work_mag_q;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                rd_add_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; the done history resets high so a held flag cannot start a sweep
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            done_prev_q  <= 1'b1;
            rd_add_q     <= '0;
            busy_q       <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_bin_q     <= '0;
            mag_valid_q  <= 1'b0;
            mag_bin_q    <= '0;
            mag_q        <= '0;
            work_mag_q   <= '0;
            work_bin_q   <= '0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
        end else begin
            state_q      <= state_d;
            done_prev_q  <= done_prev_d;
            rd_add_q     <= rd_add_d;
            busy_q       <= busy_d;
            s1_valid_q   <= s1_valid_d;
            s1_bin_q     <= s1_bin_d;
            mag_valid_q  <= mag_valid_d;
            mag_bin_q    <= mag_bin_d;
            mag_q        <= mag_d;
            work_mag_q   <= work_mag_d;
            work_bin_q   <= work_bin_d;
            peak_valid_q <= peak_valid_d;
            peak_bin_q   <= peak_bin_d;
            peak_mag_q   <= peak_mag_d;
        end
    end

    assign rd_add     = rd_add_q;
    assign busy       = busy_q;
    assign mag_valid  = mag_valid_q;
    assign mag_bin    = mag_bin_q;
    assign mag        = mag_q;
    assign peak_valid = peak_valid_q;
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;

endmodule

// File: tb/tb_fft_peak_finder.sv
// tb/tb_fft_peak_finder.sv - self-checking bench for fft_peak_finder against a behavioural spectrum model
module tb_fft_peak_finder;

    localparam int W  = 16;
    localparam int NB = 9;
    localparam int SB = 1;
    localparam int MB = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fft_done = 1'b0;
    logic [2*W-1:0] dout = '0;
    logic [NB-1:0] rd_add;
    logic          busy;
    logic          mag_valid;
    logic [NB-1:0] mag_bin;
    logic [W-1:0]  mag;
    logic          peak_valid;
    logic [NB-1:0] peak_bin;
    logic [W-1:0]  peak_mag;

    fft_peak_finder #(.BIT_WIDTH(W), .N(NB), .START_BIN(SB)) dut (
        .clk(clk), .reset(reset), .fft_done(fft_done), .dout(dout),
        .rd_add(rd_add), .busy(busy), .mag_valid(mag_valid), .mag_bin(mag_bin),
        .mag(mag), .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_mag(peak_mag)
    );

    always #5 clk = ~clk;

    logic [2*W-1:0] ram [0:2**NB-1];
    always @(posedge clk) dout <= ram[rd_add];

    typedef struct { int cyc; int bin; int val; } ev_t;
    ev_t mag_ev[$];
    ev_t peak_ev[$];
    int  addr_log [int];
    int  busy_log [int];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        addr_log[cyc] = int'(rd_add);
        busy_log[cyc] = int'(busy);
        if (mag_valid) mag_ev.push_back('{cyc, int'(mag_bin), int'(mag)});
        if (peak_valid) peak_ev.push_back('{cyc, int'(peak_bin), int'(peak_mag)});
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_abs(input int v);
        int r;
        r = (v < 0) ? -v : v;
        return (r > 32767) ? 32767 : r;
    endfunction

    function automatic int ref_mag(input logic [2*W-1:0] word);
        int a, b;
        logic signed [W-1:0] re, im;
        re = word[2*W-1:W];
        im = word[W-1:0];
        a = sat_abs(int'(re));
        b = sat_abs(int'(im));
        return (a > b) ? a + b / 2 : b + a / 2;
    endfunction

    task automatic model_peak(output int pbin, output int pmag);
        pbin = SB;
        pmag = 0;
        for (int k = SB; k < MB; k++) begin
            if (ref_mag(ram[k]) > pmag) begin
                pmag = ref_mag(ram[k]);
                pbin = k;
            end
        end
    endtask

    function automatic logic [2*W-1:0] cw(input int re, input int im);
        logic [W-1:0] r, i;
        r = W'(re);
        i = W'(im);
        return {r, i};
    endfunction

    task automatic clear_ram();
        for (int k = 0; k < 2**NB; k++) ram[k] = '0;
    endtask

    task automatic rand_ram(input bit force_tie);
        int sel, b1, b2;
        for (int k = 0; k < 2**NB; k++) begin
            sel = $urandom_range(15);
            if (sel < 2) ram[k] = '0;
            else if (sel == 2) ram[k] = cw(-32768, $urandom_range(65535));
            else ram[k] = $urandom;
        end
        if (force_tie) begin
            b1 = $urandom_range(MB - 2, SB);
            b2 = $urandom_range(MB - 1, b1 + 1);
            ram[b1] = cw(-32768, -32768);
            ram[b2] = cw(-32768, -32768);
        end
    endtask

    // One full sweep from a clean fft_done pulse, checked against the model
    task automatic do_sweep(input string tag);
        int e, pb, pm, errs;
        model_peak(pb, pm);
        mag_ev.delete();
        peak_ev.delete();
        fft_done = 1'b1;
        e = cyc;
        step();
        fft_done = 1'b0;
        repeat (270) step();
        check({tag, "_rd_first"}, addr_log[e+1], SB);
        check({tag, "_rd_last"}, addr_log[e+MB-SB], MB - 1);
        check({tag, "_rd_idle"}, addr_log[e+MB-SB+5], 0);
        check({tag, "_busy_pre"}, busy_log[e], 0);
        check({tag, "_busy_first"}, busy_log[e+1], 1);
        check({tag, "_busy_report"}, busy_log[e+MB-SB+3], 1);
        check({tag, "_busy_after"}, busy_log[e+MB-SB+4], 0);
        check({tag, "_mag_count"}, mag_ev.size(), MB - SB);
        errs = 0;
        for (int i = 0; i < mag_ev.size() && i < MB - SB; i++) begin
            if (mag_ev[i].bin != SB + i || mag_ev[i].cyc != e + 2 + SB + i ||
                mag_ev[i].val != ref_mag(ram[SB + i])) errs++;
        end
        check({tag, "_stream_errors"}, errs, 0);
        check({tag, "_peak_count"}, peak_ev.size(), 1);
        if (peak_ev.size() > 0) begin
            check({tag, "_peak_cycle"}, peak_ev[0].cyc, e + MB - SB + 3);
            check({tag, "_peak_bin_pulse"}, peak_ev[0].bin, pb);
            check({tag, "_peak_mag_pulse"}, peak_ev[0].val, pm);
        end
        check({tag, "_peak_bin_hold"}, int'(peak_bin), pb);
        check({tag, "_peak_mag_hold"}, int'(peak_mag), pm);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_add"}, int'(rd_add), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_mag_valid"}, int'(mag_valid), 0);
        check({tag, "_mag_bin"}, int'(mag_bin), 0);
        check({tag, "_mag"}, int'(mag), 0);
        check({tag, "_peak_valid"}, int'(peak_valid), 0);
        check({tag, "_peak_bin"}, int'(peak_bin), 0);
        check({tag, "_peak_mag"}, int'(peak_mag), 0);
    endtask

    initial begin
        int e, found;
        clear_ram();

        // Reset with fft_done held high across deassertion: no sweep may start
        fft_done = 1'b1;
        repeat (3) step();
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (20) step();
        check("held_through_reset_busy", int'(busy), 0);
        check("held_through_reset_mags", mag_ev.size(), 0);
        check("held_through_reset_peaks", peak_ev.size(), 0);
        fft_done = 1'b0;
        repeat (3) step();

        // Single tone at bin 37
        clear_ram();
        ram[37] = cw(1000, 0);
        do_sweep("tone");

        // RAM changes without fft_done leave the report untouched
        peak_ev.delete();
        ram[37] = '0;
        ram[80] = cw(5000, 5000);
        repeat (50) step();
        check("hold_peak_bin", int'(peak_bin), 37);
        check("hold_peak_mag", int'(peak_mag), 1000);
        check("hold_busy", int'(busy), 0);
        check("hold_no_pulse", peak_ev.size(), 0);

        // Magnitude arithmetic and abs saturation
        clear_ram();
        ram[10] = cw(3000, -4000);
        ram[20] = cw(-32768, 0);
        check("model_mag10", ref_mag(ram[10]), 5500);
        check("model_mag20", ref_mag(ram[20]), 32767);
        do_sweep("sat");
        check("sat_mag10", (mag_ev.size() > 9) ? mag_ev[9].val : -1, 5500);
        check("sat_mag20", (mag_ev.size() > 19) ? mag_ev[19].val : -1, 32767);
        check("sat_peak_bin", int'(peak_bin), 20);

        // Tie goes to the lowest bin and DC is skipped
        clear_ram();
        ram[0] = cw(20000, 0);
        ram[5] = cw(100, 100);
        ram[9] = cw(100, 100);
        do_sweep("tie");
        found = 0;
        foreach (mag_ev[i]) if (mag_ev[i].bin == 0) found++;
        check("tie_no_dc_bin", found, 0);
        check("tie_peak_bin", int'(peak_bin), 5);
        check("tie_peak_mag", int'(peak_mag), 150);

        // All-zero spectrum
        clear_ram();
        do_sweep("zero");
        check("zero_peak_bin", int'(peak_bin), SB);

        // fft_done held high for 600 cycles gives exactly one sweep
        ram[77] = cw(-1234, 321);
        mag_ev.delete();
        peak_ev.delete();
        fft_done = 1'b1;
        e = cyc;
        repeat (600) step();
        fft_done = 1'b0;
        repeat (300) step();
        check("level_peak_count", peak_ev.size(), 1);
        check("level_mag_count", mag_ev.size(), MB - SB);
        check("level_peak_cycle", (peak_ev.size() > 0) ? peak_ev[0].cyc : -1, e + MB - SB + 3);
        check("level_peak_bin", int'(peak_bin), 77);

        // Second pulse while busy is ignored
        mag_ev.delete();
        peak_ev.delete();
        fft_done = 1'b1;
        e = cyc;
        step();
        fft_done = 1'b0;
        repeat (49) step();
        check("repulse_rd_add", int'(rd_add), 50);
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        repeat (300) step();
        check("repulse_peak_count", peak_ev.size(), 1);
        check("repulse_mag_count", mag_ev.size(), MB - SB);
        check("repulse_peak_cycle", (peak_ev.size() > 0) ? peak_ev[0].cyc : -1, e + MB - SB + 3);

        // Random spectrum gives a non-zero peak ahead of the mid-sweep reset
        rand_ram(1'b0);
        do_sweep("rand1");

        // Reset for one cycle when rd_add reaches 100
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        found = 0;
        for (int t = 0; t < 400 && rd_add != 100; t++) step();
        check("midrst_rd_add", int'(rd_add), 100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_outputs_zero("midrst");
        mag_ev.delete();
        peak_ev.delete();
        repeat (300) step();
        check("midrst_no_peak", peak_ev.size(), 0);
        check("midrst_no_mag", mag_ev.size(), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_peak_mag", int'(peak_mag), 0);
        do_sweep("after_rst");

        // Further random spectra, one with a forced tie at the largest possible magnitude
        rand_ram(1'b1);
        do_sweep("rand2");
        rand_ram(1'b0);
        do_sweep("rand3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_peak_finder.md
Name: fft_peak_finder

Overview:
- Downstream consumer of the FFT core.
- After the core signals completion, it sweeps the result RAM over the non-redundant half-spectrum, bins START_BIN..2^(N-1)-1.
- It computes an approximate magnitude per bin, streams the magnitudes out, and reports the strongest bin and its magnitude.
- It drives the core's readout address (add_rd) and consumes dout.

Parameters:
BIT_WIDTH, 16, width of each real/imag component (signed two's complement)
N, 9, log2 of FFT length; M = 2^(N-1) bins swept
START_BIN, 1, first bin swept; default skips DC; legal range 0..M-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fft_done  in  1  FFT completion flag from core (pulse or level; rising edge used)
dout  in  2*BIT_WIDTH  core result {real[2W-1:W], imag[W-1:0]}, valid one cycle after rd_add
rd_add  out  N  result RAM read address, registered
busy  out  1  high while a sweep or its pipeline drain is in progress
mag_valid  out  1  mag/mag_bin valid this cycle
mag_bin  out  N  bin index of mag
mag  out  BIT_WIDTH  unsigned magnitude approximation
peak_valid  out  1  one-cycle pulse: peak_bin/peak_mag updated
peak_bin  out  N  bin with largest magnitude of last completed sweep
peak_mag  out  BIT_WIDTH  magnitude of peak_bin

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - All outputs 0.
  - State IDLE.
  - fft_done history register reset to 1, so a flag held high through reset does not start a sweep.
- Start: a sweep begins only in IDLE, on a rising edge of fft_done (sampled high in cycle e, low in e-1). Edges seen while busy are ignored.
- FSM:
  - IDLE -> SWEEP on start edge.
  - SWEEP -> DRAIN after the last address is issued.
  - DRAIN -> REPORT when the last magnitude has been compared.
  - REPORT -> IDLE after one cycle.
- Address schedule:
  - rd_add = START_BIN in cycle e+1, incrementing by 1 each cycle through M-1.
  - rd_add returns to 0 in IDLE.
  - busy is high from e+1 through the REPORT cycle inclusive.
- Pipeline: address k in cycle c -> dout valid at c+1 -> mag/mag_bin=k registered, mag_valid=1 in c+2.
- Magnitude:
  - a = |re|, b = |im|; abs saturates, so -2^(W-1) -> 2^(W-1)-1.
  - mag = max(a,b) + (min(a,b) >> 1), unsigned, BIT_WIDTH bits; cannot overflow.
- Peak tracking:
  - The working max is cleared to mag 0, bin START_BIN at sweep start.
  - It updates only when mag > working max (strict), so the lowest bin wins ties.
- Report:
  - peak_valid pulses in the cycle after the last mag_valid, i.e. e + (M - START_BIN) + 3.
  - peak_bin/peak_mag load from the working regs in that same cycle and hold until the next peak_valid.
- All-zero spectrum -> peak_bin = START_BIN, peak_mag = 0.
- Reset mid-sweep:
  - Immediate return to reset values; no peak_valid.
  - No restart until a fresh rising edge of fft_done.
- dout is ignored outside the pipeline slots; mag_valid is low in IDLE.

Decomposition:
- Shared package fft_pkg: BIT_WIDTH/N defaults, peak FSM state enum (IDLE, SWEEP, DRAIN, REPORT), complex field slice helpers (re/im extraction).
- One combinational sub-module, cmag_approx: saturating abs plus max+min/2 on a {re,im} word, producing a BIT_WIDTH magnitude.
- Top level holds the FSM, address counter, pipeline registers and peak registers.

Test Plan:
Bench conventions: behavioural 1-cycle-latency RAM model drives dout from rd_add; defaults N=9, START_BIN=1, M=256.
- Single tone: bin 37 = {1000,0}, all others 0; pulse fft_done at cycle e -> rd_add=1 at e+1, 255 at e+255; peak_valid only at e+258; peak_bin=37, peak_mag=1000; exactly 255 mag_valid cycles, bins 1..255 in order.
- Magnitude/saturation: bin 10 = {3000,-4000}, bin 20 = {-32768,0} -> mag(10)=5500, mag(20)=32767; peak_bin=20, peak_mag=32767.
- Tie and DC skip:
  - bin 0 = {20000,0}, bins 5 and 9 = {100,100} -> mag_bin never 0; peak_bin=5, peak_mag=150.
  - All-zero RAM -> peak_bin=1, peak_mag=0.
- Start rules:
  - fft_done held high for 600 cycles -> exactly one sweep.
  - Second fft_done pulse at rd_add=50 -> ignored, single peak_valid.
  - fft_done high across reset deassertion -> no sweep.
- Reset mid-sweep: reset for 1 cycle when rd_add=100 -> next cycle all outputs 0, busy=0, no peak_valid; previous peak cleared to 0; a new fft_done edge then runs a full sweep with correct result.
- Hold: after a sweep reporting bin 37, change RAM contents, no fft_done -> peak_bin/peak_mag stay 37/1000 and busy stays 0.
